mux_rr_sched: RTL



---
 rtl/mux_rr_sched_pkg.sv | 13 +
 rtl/mux_rr_sched_rr_pick8.sv | 28 ++
 rtl/mux_rr_sched.sv | 105 ++++++++++
 3 files changed

// File: rtl/mux_rr_sched_pkg.sv
// Shared types and sizes for the round-robin byte-mux scheduler.
// Imported by the scheduler top and its pick sub-module.
package mux_rr_sched_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mux_rr_sched_rr_pick8.sv
// Combinational 8-way winner pick: rotating search from base,
// or lowest set index when fixed priority is requested.
module rr_pick8
  import mux_rr_sched_pkg::*;
(
  input  logic [N_REQ-1:0] i_eligible,
  input  logic [SEL_W-1:0] i_base,
  input  logic             i_fixed,
  output logic [SEL_W-1:0] o_winner,
  output logic             o_found
);

  logic [SEL_W-1:0] w_idx;

  always_comb begin
    o_winner = '0;
    o_found  = 1'b0;
    w_idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = i_fixed ? SEL_W'(i) : i_base + SEL_W'(i);
      if (!o_found && i_eligible[w_idx]) begin
        o_winner = w_idx;
        o_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler sharing an 8-to-1 byte mux between requesters,
// with a valid/ready consumer port, one-hot ack and a stall timeout.
module mux_rr_sched
  import mux_rr_sched_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] en_mask,
  input  logic             fixed_prio,
  output logic [SEL_W-1:0] mux_sel,
  input  logic [WIDTH-1:0] mux_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SEL_W-1:0] out_src,
  output logic [N_REQ-1:0] ack,
  output logic             timeout,
  output logic             busy
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           r_state;
  state_t           w_next;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_last;
  logic [CNT_W-1:0] r_cnt;
  logic             r_to;

  logic [N_REQ-1:0] w_elig;
  logic [SEL_W-1:0] w_base;
  logic [SEL_W-1:0] w_win;
  logic             w_found;
  logic             w_busy;
  logic             w_valid;
  logic             w_hs;
  logic             w_to_hit;
  logic             w_done;

  assign w_elig = req & en_mask;
  assign w_base = r_last + 3'd1;

  rr_pick8 u_pick (
    .i_eligible (w_elig),
    .i_base     (w_base),
    .i_fixed    (fixed_prio),
    .o_winner   (w_win),
    .o_found    (w_found)
  );

  assign w_busy   = (r_state == BUSY);
  assign w_valid  = w_busy & req[r_sel];
  assign w_hs     = w_valid & out_ready;
  // A handshake on the last allowed cycle beats the timeout.
  assign w_to_hit = (TIMEOUT != 0) && w_valid &&
                    (r_cnt == CNT_LAST) && !w_hs;
  assign w_done   = w_busy & (w_hs | ~req[r_sel] | w_to_hit);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_found) w_next = BUSY;
      BUSY: if (w_done)  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_last  <= 3'd7;
      r_cnt   <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_to    <= w_to_hit;
      if (!w_busy && w_found) begin
        r_sel <= w_win;
        r_cnt <= '0;
      end
      if (w_busy) begin
        if (w_done)
          r_last <= r_sel;
        else if (r_cnt != '1)
          r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign mux_sel   = r_sel;
  assign out_valid = w_valid;
  assign out_data  = mux_y;
  assign out_src   = r_sel;
  assign ack       = w_hs ? (N_REQ'(1) << r_sel) : '0;
  assign timeout   = r_to;
  assign busy      = w_busy;

endmodule
